// File: rtl/user_io_ctrl.sv
// user_io_ctrl: Wishbone pad controller for the 16 packed user IO pads.
// Optional LA pad override is built when USER_IO_LA_OVERRIDE_EN is defined.
module user_io_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          PADS      = 16,
    parameter logic [31:0] ID_VALUE  = 32'h2304_C001
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    input  logic [127:0]    la_data_in,
    input  logic [127:0]    la_oenb,
    output logic [127:0]    la_data_out,
    input  logic [PADS-1:0] io_in,
    output logic [PADS-1:0] io_out,
    output logic [PADS-1:0] io_oeb,
    output logic [2:0]      irq
);

    localparam logic [7:0] OFF_OUT  = 8'h00;
    localparam logic [7:0] OFF_OEB  = 8'h04;
    localparam logic [7:0] OFF_IN   = 8'h08;
    localparam logic [7:0] OFF_EN   = 8'h0C;
    localparam logic [7:0] OFF_STAT = 8'h10;
    localparam logic [7:0] OFF_ID   = 8'h14;

    logic [PADS-1:0] out_q;
    logic [PADS-1:0] oeb_q;
    logic [PADS-1:0] sync1_q;
    logic [PADS-1:0] in_q;
    logic [PADS-1:0] prev_q;
    logic [PADS-1:0] en_rise_q;
    logic [PADS-1:0] en_fall_q;
    logic [PADS-1:0] st_rise_q;
    logic [PADS-1:0] st_fall_q;
    logic            ack_q;
    logic [31:0]     dat_q;
    logic [1:0]      irq_q;

    logic            hit;
    logic            req;
    logic            wr;
    logic [31:0]     bmask;
    logic [31:0]     w1c;
    logic [31:0]     rdata;
    logic            sel_out;
    logic            sel_oeb;
    logic            sel_in;
    logic            sel_en;
    logic            sel_stat;
    logic            sel_id;
    logic [PADS-1:0] rise;
    logic [PADS-1:0] fall;
    logic [PADS-1:0] pad_out;
    logic [PADS-1:0] pad_oeb;

    // Byte-lane merge of a write word into a PADS-wide register.
    function automatic logic [PADS-1:0] merge(
        input logic [PADS-1:0] old,
        input logic [31:0]     d,
        input logic [31:0]     m
    );
        logic [31:0] w;
        w = (32'(old) & ~m) | (d & m);
        return w[PADS-1:0];
    endfunction

    assign hit   = wbs_adr_i[31:8] == BASE_ADDR[31:8];
    assign req   = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign wr    = req & wbs_we_i;
    assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                    {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign w1c   = wbs_dat_i & bmask;

    assign sel_out  = wbs_adr_i[7:0] == OFF_OUT;
    assign sel_oeb  = wbs_adr_i[7:0] == OFF_OEB;
    assign sel_in   = wbs_adr_i[7:0] == OFF_IN;
    assign sel_en   = wbs_adr_i[7:0] == OFF_EN;
    assign sel_stat = wbs_adr_i[7:0] == OFF_STAT;
    assign sel_id   = wbs_adr_i[7:0] == OFF_ID;

    assign rise = in_q & ~prev_q;
    assign fall = ~in_q & prev_q;

    // Register read mux; unmapped offsets and bits above PADS read 0.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_out: rdata[PADS-1:0] = out_q;
            sel_oeb: rdata[PADS-1:0] = oeb_q;
            sel_in:  rdata[PADS-1:0] = in_q;
            sel_en: begin
                rdata[PADS-1:0]     = en_rise_q;
                rdata[16+PADS-1:16] = en_fall_q;
            end
            sel_stat: begin
                rdata[PADS-1:0]     = st_rise_q;
                rdata[16+PADS-1:16] = st_fall_q;
            end
            sel_id:  rdata = ID_VALUE;
            default: rdata = '0;
        endcase
    end

    // Bus handshake: one-cycle ack, read data only while acking.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req;
            dat_q <= (req & ~wbs_we_i) ? rdata : '0;
        end
    end

    // Writable control registers, committed on the acking edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            out_q     <= '0;
            oeb_q     <= '1;
            en_rise_q <= '0;
            en_fall_q <= '0;
        end else begin
            if (wr & sel_out)
                out_q <= merge(out_q, wbs_dat_i, bmask);
            if (wr & sel_oeb)
                oeb_q <= merge(oeb_q, wbs_dat_i, bmask);
            if (wr & sel_en) begin
                en_rise_q <= merge(en_rise_q, wbs_dat_i, bmask);
                en_fall_q <= merge(en_fall_q, wbs_dat_i >> 16,
                                   bmask >> 16);
            end
        end
    end

    // Two-flop input synchronizer plus one delayed copy for edges.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            in_q    <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= io_in;
            in_q    <= sync1_q;
            prev_q  <= in_q;
        end
    end

    // Sticky edge status; a new edge beats a same-cycle clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            st_rise_q <= '0;
            st_fall_q <= '0;
            irq_q     <= '0;
        end else begin
            st_rise_q <= (st_rise_q
                          & ~((wr & sel_stat) ? w1c[PADS-1:0] : '0))
                         | (rise & en_rise_q);
            st_fall_q <= (st_fall_q
                          & ~((wr & sel_stat) ? w1c[16+PADS-1:16] : '0))
                         | (fall & en_fall_q);
            irq_q     <= {|st_fall_q, |st_rise_q};
        end
    end

`ifdef USER_IO_LA_OVERRIDE_EN
    logic unused_la;
    assign unused_la = &{1'b0, la_data_in[127:PADS], la_oenb[127:PADS]};

    // LA takes a pad over whenever its active-low enable is low.
    always_comb begin
        pad_out = (out_q & la_oenb[PADS-1:0])
                | (la_data_in[PADS-1:0] & ~la_oenb[PADS-1:0]);
        pad_oeb = oeb_q & la_oenb[PADS-1:0];
    end

    // LA readback of synchronized inputs and effective enables.
    always_comb begin
        la_data_out                = '0;
        la_data_out[PADS-1:0]      = in_q;
        la_data_out[16+PADS-1:16]  = pad_oeb;
    end
`else
    logic unused_la;
    assign unused_la = &{1'b0, la_data_in, la_oenb};

    // Pads follow the registers directly.
    always_comb begin
        pad_out     = out_q;
        pad_oeb     = oeb_q;
        la_data_out = '0;
    end
`endif

    assign io_out    = pad_out;
    assign io_oeb    = pad_oeb;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = {1'b0, irq_q};

endmodule

// File: tb/tb_user_io_ctrl.sv
// tb_user_io_ctrl: directed and random checks of user_io_ctrl
// against a cycle-level register/pad model.
module tb_user_io_ctrl;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] IDV  = 32'h2304_C001;

    logic         clk = 1'b0;
    logic         rst;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [3:0]   sel;
    logic [31:0]  adr;
    logic [31:0]  wdat;
    logic [127:0] la_in;
    logic [127:0] la_oenb;
    logic [15:0]  pin;
    logic         ack;
    logic [31:0]  dat_o;
    logic [127:0] la_out;
    logic [15:0]  pout;
    logic [15:0]  poeb;
    logic [2:0]   irq;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    // reference model state
    logic [15:0] out_m;
    logic [15:0] oeb_m;
    logic [31:0] en_m;
    logic [31:0] stat_m;
    logic [1:0]  irq_m;
    logic        ack_m;
    logic [31:0] dat_m;
    logic [15:0] smp[$];

    always #5 clk = ~clk;

    user_io_ctrl dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (wdat),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .la_data_in  (la_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_out),
        .io_in       (pin),
        .io_out      (pout),
        .io_oeb      (poeb),
        .irq         (irq)
    );

    // pad sample taken n edges ago (0 = most recent edge)
    function automatic logic [15:0] past(input int n);
        if (n < smp.size()) return smp[n];
        return 16'h0;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [15:0] rise;
        logic [15:0] fall;
        logic [31:0] setm;
        logic [31:0] clr;
        logic [31:0] bm;
        logic [31:0] rd;
        logic [31:0] tmp;
        logic        req;
        if (rst) begin
            out_m  = 16'h0;
            oeb_m  = 16'hFFFF;
            en_m   = 32'h0;
            stat_m = 32'h0;
            irq_m  = 2'b00;
            ack_m  = 1'b0;
            dat_m  = 32'h0;
            smp.delete();
            smp.push_front(16'h0);
            return;
        end
        rise = past(1) & ~past(2);
        fall = ~past(1) & past(2);
        setm = {fall, rise} & en_m;
        req  = cyc && stb && (adr[31:8] == BASE[31:8]) && !ack_m;
        bm   = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
        case (adr[7:0])
            8'h00:   rd = {16'h0, out_m};
            8'h04:   rd = {16'h0, oeb_m};
            8'h08:   rd = {16'h0, past(1)};
            8'h0C:   rd = en_m;
            8'h10:   rd = stat_m;
            8'h14:   rd = IDV;
            default: rd = 32'h0;
        endcase
        dat_m = (req && !we) ? rd : 32'h0;
        irq_m = {|stat_m[31:16], |stat_m[15:0]};
        clr = 32'h0;
        if (req && we) begin
            case (adr[7:0])
                8'h00: begin
                    tmp = ({16'h0, out_m} & ~bm) | (wdat & bm);
                    out_m = tmp[15:0];
                end
                8'h04: begin
                    tmp = ({16'h0, oeb_m} & ~bm) | (wdat & bm);
                    oeb_m = tmp[15:0];
                end
                8'h0C: en_m = (en_m & ~bm) | (wdat & bm);
                8'h10: clr = wdat & bm;
                default: ;
            endcase
        end
        stat_m = (stat_m & ~clr) | setm;
        ack_m  = req;
        smp.push_front(pin);
        if (smp.size() > 8) void'(smp.pop_back());
    endtask

    task automatic check_outputs();
        logic [15:0]  e_out;
        logic [15:0]  e_oeb;
        logic [127:0] e_la;
`ifdef USER_IO_LA_OVERRIDE_EN
        e_out = (out_m & la_oenb[15:0]) | (la_in[15:0] & ~la_oenb[15:0]);
        e_oeb = oeb_m & la_oenb[15:0];
        e_la  = {96'h0, e_oeb, past(1)};
`else
        e_out = out_m;
        e_oeb = oeb_m;
        e_la  = 128'h0;
`endif
        chk("ack", ack, ack_m);
        chk("dat_o", dat_o, dat_m);
        chk("io_out", pout, e_out);
        chk("io_oeb", poeb, e_oeb);
        chk("irq", irq, {1'b0, irq_m});
        chk("la_out", la_out, e_la);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (chk_on) check_outputs();
    endtask

    // one bus transfer followed by an idle cycle
    task automatic wb(input logic [31:0] a, input logic w,
                      input logic [3:0] s, input logic [31:0] d,
                      output logic [31:0] r);
        int n;
        cyc = 1'b1; stb = 1'b1;
        adr = a; we = w; sel = s; wdat = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (ack !== 1'b1 && n < 8);
        r = dat_o;
        chk("ack_latency", n, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        int k;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        la_in = '0; la_oenb = '1; pin = 16'h0;
        tick();
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        wb(BASE + 32'h04, 1'b0, 4'hF, 32'h0, rd);
        chk("oeb_reset", rd, 32'h0000_FFFF);
        wb(BASE + 32'h14, 1'b0, 4'hF, 32'h0, rd);
        chk("id", rd, IDV);
        chk("pads_in", poeb, 16'hFFFF);

        wb(BASE + 32'h00, 1'b1, 4'b0001, 32'h0000_A5A5, rd);
        wb(BASE + 32'h00, 1'b0, 4'hF, 32'h0, rd);
        chk("out_lane0", rd, 32'h0000_00A5);
        chk("io_out_a5", pout, 16'h00A5);
        wb(BASE + 32'h04, 1'b1, 4'hF, 32'h0, rd);
        chk("io_oeb_0", poeb, 16'h0000);

        wb(BASE + 32'h0C, 1'b1, 4'hF, 32'h0000_0001, rd);
        pin[0] = 1'b1;
        tick(); tick(); tick();
        chk("irq_pre", irq, 3'b000);
        tick();
        chk("irq_rise", irq, 3'b001);
        wb(BASE + 32'h08, 1'b0, 4'hF, 32'h0, rd);
        chk("in_reg", rd, 32'h0000_0001);
        wb(BASE + 32'h10, 1'b0, 4'hF, 32'h0, rd);
        chk("stat_rise", rd, 32'h0000_0001);
        wb(BASE + 32'h10, 1'b1, 4'hF, 32'h0000_0001, rd);
        chk("irq_cleared", irq, 3'b000);

        wb(BASE + 32'h0C, 1'b1, 4'hF, 32'h0001_0001, rd);
        pin[0] = 1'b0;
        tick(); tick(); tick(); tick();
        wb(BASE + 32'h10, 1'b0, 4'hF, 32'h0, rd);
        chk("stat_fall", rd, 32'h0001_0000);
        chk("irq_fall", irq, 3'b010);
        pin[0] = 1'b1;
        tick(); tick(); tick(); tick();
        pin[0] = 1'b0;
        tick(); tick();
        wb(BASE + 32'h10, 1'b1, 4'hF, 32'h0001_0000, rd);
        wb(BASE + 32'h10, 1'b0, 4'hF, 32'h0, rd);
        chk("set_wins", rd, 32'h0001_0001);
        chk("irq_both", irq, 3'b011);

        cyc = 1'b1; stb = 1'b1; we = 1'b0;
        adr = BASE + 32'h100; sel = 4'hF;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("oow_noack", ack, 1'b0);
        end
        adr = BASE; we = 1'b1; wdat = 32'h0000_1234;
        rst = 1'b1;
        tick();
        chk("rst_ack", ack, 1'b0);
        chk("rst_out", pout, 16'h0000);
        chk("rst_oeb", poeb, 16'hFFFF);
        chk("rst_irq", irq, 3'b000);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        wb(BASE + 32'h00, 1'b0, 4'hF, 32'h0, rd);
        chk("rst_out_rd", rd, 32'h0);

`ifdef USER_IO_LA_OVERRIDE_EN
        la_oenb[3] = 1'b0;
        la_in[3]   = 1'b1;
        tick();
        chk("la_oeb3", poeb[3], 1'b0);
        chk("la_out3", pout[3], 1'b1);
        chk("la_rb19", la_out[19], 1'b0);
        la_oenb = '1;
        la_in   = '0;
        tick();
`endif

        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 2) == 0)
                pin = pin ^ (16'($urandom) & 16'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, 6);
                wb(BASE + 32'(k * 4), 1'($urandom_range(0, 1)),
                   4'($urandom), $urandom, rd);
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
